// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO and its launch sequencer.
// Sequencer state encoding and the default FIFO depth live here.
package uart_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACT  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } seq_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered count/full/empty and synchronous flush.
// The head byte is presented combinationally so a pop can capture it at the same edge.
module uart_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  flush_i,
  output logic [7:0]            rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic                  full_q,   full_d;
  logic                  empty_q,  empty_d;
  logic                  wr_accept;
  logic                  rd_accept;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    wr_accept = wr_en_i && !full_q;
    rd_accept = rd_en_i && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CNT_ONE;
      end else if (!wr_accept && rd_accept) begin
        count_d = count_q - CNT_ONE;
      end
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule : uart_sync_fifo

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one frame at a time.
// Define UART_TX_FIFO_OVF_EN to add the sticky o_overflow flag and its i_ovf_clr input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_Clock,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_flush,
`ifdef UART_TX_FIFO_OVF_EN
  input  logic                  i_ovf_clr,
  output logic                  o_overflow,
`endif
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_busy,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done
);

  seq_state_e  state_q, state_d;
  logic        tx_dv_q;
  logic        busy_q;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        pop;
  logic [7:0]  head_byte;
  logic        fifo_full;
  logic        fifo_empty;

  uart_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (i_Clock),
    .rst_n     (rst_n),
    .wr_en_i   (i_wr_en),
    .wr_data_i (i_wr_data),
    .rd_en_i   (pop),
    .flush_i   (i_flush),
    .rd_data_o (head_byte),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (o_count)
  );

  // The IDLE exit looks at the registered empty flag, so a same-cycle flush
  // cannot cancel a launch that has already been decided.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !i_tx_active) begin
          pop       = 1'b1;
          tx_byte_d = head_byte;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_ACT;
      S_WAIT_ACT:  if (i_tx_active) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done)   state_d = S_GAP;
      S_GAP:       if (!i_tx_done)  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= (state_d == S_LAUNCH);
      busy_q    <= (state_d != S_IDLE);
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_full    = fifo_full;
  assign o_empty   = fifo_empty;
  assign o_busy    = busy_q;
  assign o_tx_dv   = tx_dv_q;
  assign o_tx_byte = tx_byte_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // A dropped write sets the flag even when a clear or flush arrives with it.
  always_comb begin
    ovf_d = ovf_q;
    if (i_wr_en && fifo_full) begin
      ovf_d = 1'b1;
    end else if (i_ovf_clr || i_flush) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`endif

endmodule : uart_tx_fifo
